// File: rtl/sap1_controller.sv
// SAP-1 instruction register and T1-T6 controller-sequencer.
// Decodes state and opcode into the datapath control word and drives the operand nibble onto the bus.
module sap1_controller #(
    parameter bit FAST_CYCLE = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset_n,
    inout  wire  [7:0] data_bus,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm,
    output logic       Er,
    output logic       Li,
    output logic       Ei,
    output logic       La,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb,
    output logic       Lo,
    output logic       halted,
    output logic [3:0] ir_opcode,
    output logic [5:0] t_state
);
    // state  | meaning
    // S_T1   | fetch: PC onto bus, MAR load
    // S_T2   | fetch: PC increment
    // S_T3   | fetch: memory onto bus, IR load
    // S_T4   | execute step 1 (HLT leaves for S_HALT from here)
    // S_T5   | execute step 2
    // S_T6   | execute step 3
    // S_HALT | stopped until reset
    typedef enum logic [2:0] {S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_t;

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b0100;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef struct packed {
        logic cp, ep, lm, er, li, ei, la, ea, su, eu, lb, lo;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    ctrl_t      ctrl_dec, ctrl;
    logic [3:0] opcode;

    assign opcode = ir_q[7:4];

    always_comb begin
        ctrl_dec = '0;
        unique case (state_q)
            S_T1: begin ctrl_dec.ep = 1'b1; ctrl_dec.lm = 1'b1; end
            S_T2: ctrl_dec.cp = 1'b1;
            S_T3: begin ctrl_dec.er = 1'b1; ctrl_dec.li = 1'b1; end
            S_T4: begin
                if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl_dec.ei = 1'b1;
                    ctrl_dec.lm = 1'b1;
                end else if (opcode == OP_OUT) begin
                    ctrl_dec.ea = 1'b1;
                    ctrl_dec.lo = 1'b1;
                end
            end
            S_T5: begin
                if (opcode == OP_LDA) begin
                    ctrl_dec.er = 1'b1;
                    ctrl_dec.la = 1'b1;
                end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl_dec.er = 1'b1;
                    ctrl_dec.lb = 1'b1;
                end
            end
            S_T6: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl_dec.eu = 1'b1;
                    ctrl_dec.la = 1'b1;
                    ctrl_dec.su = (opcode == OP_SUB);
                end
            end
            default: ctrl_dec = '0;
        endcase
    end

    // Reset gates the word directly so the T1 decode never leaks out while held in reset.
    assign ctrl = Reset_n ? ctrl_dec : '0;

    always_comb begin
        state_d = state_q;
        ir_d    = ctrl_dec.li ? data_bus : ir_q;
        unique case (state_q)
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: state_d = S_T4;
            S_T4: begin
                if (opcode == OP_HLT)
                    state_d = S_HALT;
                else if (FAST_CYCLE && opcode != OP_LDA && opcode != OP_ADD && opcode != OP_SUB)
                    state_d = S_T1;
                else
                    state_d = S_T5;
            end
            S_T5:    state_d = (FAST_CYCLE && opcode == OP_LDA) ? S_T1 : S_T6;
            S_T6:    state_d = S_T1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_T1;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_T1;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        t_state = 6'b000000;
        unique case (state_q)
            S_T1:    t_state = 6'b000001;
            S_T2:    t_state = 6'b000010;
            S_T3:    t_state = 6'b000100;
            S_T4:    t_state = 6'b001000;
            S_T5:    t_state = 6'b010000;
            S_T6:    t_state = 6'b100000;
            default: t_state = 6'b000000;
        endcase
    end

    assign data_bus  = ctrl.ei ? {4'b0000, ir_q[3:0]} : 8'bz;
    assign halted    = (state_q == S_HALT);
    assign ir_opcode = opcode;

    assign Cp = ctrl.cp;
    assign Ep = ctrl.ep;
    assign Lm = ctrl.lm;
    assign Er = ctrl.er;
    assign Li = ctrl.li;
    assign Ei = ctrl.ei;
    assign La = ctrl.la;
    assign Ea = ctrl.ea;
    assign Su = ctrl.su;
    assign Eu = ctrl.eu;
    assign Lb = ctrl.lb;
    assign Lo = ctrl.lo;
endmodule

// File: tb/tb_sap1_controller.sv
// Bench for sap1_controller: two instances (FAST_CYCLE 0 and 1) each with behavioural PC, MAR, memory, A, B, ALU.
module tb_sap1_controller;
    logic clk;
    logic rst_n;

    wire  [7:0] bus0, bus1;
    logic [7:0] bus_v [2];
    logic [1:0] cp, ep, lm, er, li, ei, la, ea, su, eu, lb, lo, hlt;
    logic [3:0] opc0, opc1;
    logic [5:0] ts0, ts1;

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    logic [3:0] pc  [2];
    logic [3:0] mar [2];
    logic [7:0] a_r [2];
    logic [7:0] b_r [2];
    logic [7:0] drv_val0, drv_val1;
    logic [7:0] lo_log0 [$];
    logic [7:0] lo_log1 [$];

    int n_checks = 0;
    int n_err    = 0;
    int h0, h1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pullup (bus0);
    pullup (bus1);

    sap1_controller #(.FAST_CYCLE(1'b0)) u_dut0 (
        .Clock(clk), .Reset_n(rst_n), .data_bus(bus0),
        .Cp(cp[0]), .Ep(ep[0]), .Lm(lm[0]), .Er(er[0]), .Li(li[0]), .Ei(ei[0]),
        .La(la[0]), .Ea(ea[0]), .Su(su[0]), .Eu(eu[0]), .Lb(lb[0]), .Lo(lo[0]),
        .halted(hlt[0]), .ir_opcode(opc0), .t_state(ts0)
    );

    sap1_controller #(.FAST_CYCLE(1'b1)) u_dut1 (
        .Clock(clk), .Reset_n(rst_n), .data_bus(bus1),
        .Cp(cp[1]), .Ep(ep[1]), .Lm(lm[1]), .Er(er[1]), .Li(li[1]), .Ei(ei[1]),
        .La(la[1]), .Ea(ea[1]), .Su(su[1]), .Eu(eu[1]), .Lb(lb[1]), .Lo(lo[1]),
        .halted(hlt[1]), .ir_opcode(opc1), .t_state(ts1)
    );

    assign bus_v[0] = bus0;
    assign bus_v[1] = bus1;

    always_comb begin
        drv_val0 = er[0] ? mem0[mar[0]] : ep[0] ? {4'b0000, pc[0]} : ea[0] ? a_r[0] :
                   (su[0] ? a_r[0] - b_r[0] : a_r[0] + b_r[0]);
        drv_val1 = er[1] ? mem1[mar[1]] : ep[1] ? {4'b0000, pc[1]} : ea[1] ? a_r[1] :
                   (su[1] ? a_r[1] - b_r[1] : a_r[1] + b_r[1]);
    end

    assign bus0 = (er[0] | ep[0] | ea[0] | eu[0]) ? drv_val0 : 8'bz;
    assign bus1 = (er[1] | ep[1] | ea[1] | eu[1]) ? drv_val1 : 8'bz;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                pc[k]  <= 4'd0;
                mar[k] <= 4'd0;
            end else begin
                if (cp[k]) pc[k]  <= pc[k] + 4'd1;
                if (lm[k]) mar[k] <= bus_v[k][3:0];
                if (la[k]) a_r[k] <= bus_v[k];
                if (lb[k]) b_r[k] <= bus_v[k];
                if (lo[k]) begin
                    if (k == 0) lo_log0.push_back(bus_v[0]);
                    else        lo_log1.push_back(bus_v[1]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] cw(input int k);
        return {cp[k], ep[k], lm[k], er[k], li[k], ei[k], la[k], ea[k], su[k], eu[k], lb[k], lo[k]};
    endfunction

    // At most one bus driver per instance in every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++)
                chk($sformatf("one_driver%0d", k),
                    32'($countones({ep[k], er[k], ei[k], ea[k], eu[k]}) <= 1), 32'd1);
        end
    end

    task automatic load_prog_main();
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        mem0[0] = 8'h1D; mem0[1] = 8'h40; mem0[2] = 8'h2E; mem0[3] = 8'h40;
        mem0[4] = 8'h3F; mem0[5] = 8'h40; mem0[6] = 8'hF0;
        mem0[13] = 8'd8; mem0[14] = 8'd5; mem0[15] = 8'd4;
        for (int i = 0; i < 16; i++) mem1[i] = mem0[i];
    endtask

    task automatic release_rst();
        @(negedge clk);
        lo_log0.delete();
        lo_log1.delete();
        rst_n = 1'b1;
        #1;
    endtask

    // Runs until both instances halt (or budget expires); mode 1 adds NOP-window checks.
    task automatic run(input int mode, output int hc0, output int hc1);
        hc0 = -1;
        hc1 = -1;
        for (int c = 0; c < 80 && (hc0 < 0 || hc1 < 0); c++) begin
            if (c == 0) begin
                chk("t1_ctrl0", 32'(cw(0)), 32'h600);
                chk("t1_ctrl1", 32'(cw(1)), 32'h600);
                chk("t1_state0", 32'(ts0), 32'h01);
            end
            if (mode == 0 && c == 3) begin
                chk("lda_t4_ei", 32'(ei[0]), 32'd1);
                chk("lda_t4_bus", 32'(bus0), 32'h0D);
            end
            if (mode == 1 && c >= 3 && c <= 5) begin
                chk($sformatf("nop_ctrl_c%0d", c), 32'(cw(0)), 32'h0);
                chk($sformatf("nop_bus_c%0d", c), 32'(bus0), 32'hFF);
            end
            if (hlt[0] && hc0 < 0) hc0 = c;
            if (hlt[1] && hc1 < 0) hc1 = c;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load_prog_main();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctrl0", 32'(cw(0)), 32'h0);
        chk("rst_ctrl1", 32'(cw(1)), 32'h0);
        chk("rst_tstate", 32'(ts0), 32'h01);
        chk("rst_halted", 32'(hlt), 32'h0);
        chk("rst_bus", 32'(bus0), 32'hFF);

        // Full program on both instances.
        release_rst();
        run(0, h0, h1);
        chk("halt_cyc0", 32'(h0), 32'd40);
        chk("halt_cyc1", 32'(h1), 32'd33);
        chk("lo_cnt0", 32'(lo_log0.size()), 32'd3);
        chk("lo_cnt1", 32'(lo_log1.size()), 32'd3);
        if (lo_log0.size() == 3) begin
            chk("lo0_0", 32'(lo_log0[0]), 32'd8);
            chk("lo0_1", 32'(lo_log0[1]), 32'd13);
            chk("lo0_2", 32'(lo_log0[2]), 32'd9);
        end
        if (lo_log1.size() == 3) begin
            chk("lo1_0", 32'(lo_log1[0]), 32'd8);
            chk("lo1_1", 32'(lo_log1[1]), 32'd13);
            chk("lo1_2", 32'(lo_log1[2]), 32'd9);
        end

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_ctrl", 32'({cw(0), cw(1)}), 32'h0);
            chk("halt_ts", 32'({ts0, ts1}), 32'h0);
            chk("halt_flag", 32'(hlt), 32'h3);
        end

        rst_n = 1'b0;
        @(negedge clk);
        release_rst();
        chk("unhalt_flag", 32'(hlt), 32'h0);
        chk("unhalt_ctrl0", 32'(cw(0)), 32'h600);
        chk("unhalt_ts0", 32'(ts0), 32'h01);

        // Abort mid-T5 of ADD (third instruction, starts at cycle 12).
        rst_n = 1'b0;
        load_prog_main();
        @(negedge clk);
        release_rst();
        repeat (16) @(negedge clk);
        #1;
        chk("pre_abort_ts", 32'(ts0), 32'h10);
        chk("pre_abort_op", 32'(opc0), 32'h2);
        chk("pre_abort_ctrl", 32'(cw(0)), 32'h102);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("abort_ctrl", 32'(cw(0)), 32'h0);
            chk("abort_op", 32'(opc0), 32'h0);
            chk("abort_ts", 32'(ts0), 32'h01);
            chk("abort_bus", 32'(bus0), 32'hFF);
            @(negedge clk);
            #1;
        end

        // NOP (0x5A) then OUT then HLT; A holds 8 (inst0) and 13 (inst1) after the abort.
        mem0[0] = 8'h5A; mem0[1] = 8'h40; mem0[2] = 8'hF0;
        mem1[0] = 8'h5A; mem1[1] = 8'h40; mem1[2] = 8'hF0;
        @(negedge clk);
        chk("abort_release_t1", 32'(ep[0] & lm[0]), 32'd0);
        release_rst();
        run(1, h0, h1);
        chk("nop_halt0", 32'(h0), 32'd16);
        chk("nop_halt1", 32'(h1), 32'd12);
        chk("nop_lo_cnt0", 32'(lo_log0.size()), 32'd1);
        if (lo_log0.size() == 1) chk("nop_lo0", 32'(lo_log0[0]), 32'd8);
        chk("nop_lo_cnt1", 32'(lo_log1.size()), 32'd1);
        if (lo_log1.size() == 1) chk("nop_lo1", 32'(lo_log1[0]), 32'd13);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/sap1_controller.md
# sap1_controller

Instruction register plus controller-sequencer for the SAP-1 datapath. It sits directly downstream of the memory address register/ROM block. It latches the instruction byte that the memory drives onto the shared 8-bit bus, steps a T1–T6 ring sequence, and decodes opcode and T-state into the control word for every other block: PC, MAR, memory, A, B, ALU and output register. It also drives the instruction operand nibble back onto the bus for address loading.

## Interface
Parameters:
- FAST_CYCLE, default 0: when 1, the sequencer returns to T1 as soon as an instruction has no further work; when 0, every non-halt instruction takes exactly 6 cycles.

Ports (control outputs are active-high):
- Clock  input  1  system clock; all state changes occur on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- data_bus  inout  8  shared system bus. The IR loads from it and drives {4'b0000, operand} onto it when Ei=1; otherwise it is high-Z.
- Cp  output  1  PC increment.
- Ep  output  1  PC drives bus.
- Lm  output  1  MAR load; connects to the memory block's enable_input.
- Er  output  1  memory drives bus; connects to the memory block's enable_output.
- Li  output  1  IR load (internal use, also exported).
- Ei  output  1  IR operand drives bus.
- La  output  1  A load.
- Ea  output  1  A drives bus.
- Su  output  1  ALU subtract (0 selects add).
- Eu  output  1  ALU drives bus.
- Lb  output  1  B load.
- Lo  output  1  output register load.
- halted  output  1  high while in HALT.
- ir_opcode  output  4  IR[7:4], for debug.
- t_state  output  6  one-hot state, bit0 = T1 … bit5 = T6; all zero in HALT.

## Operation
- Opcodes: LDA=0001, ADD=0010, SUB=0011, OUT=0100, HLT=1111. All other opcodes are NOPs (no control in T4–T6).
- IR: 8-bit register, reset 0x00. It loads data_bus on a rising edge while Li=1.
- States: T1..T6 and HALT. Reset enters T1. Without FAST_CYCLE, the state advances every edge T1→…→T6→T1.
- The control word decodes combinationally from the state and the IR. Any signal not listed for a state is 0.
- Fetch (all opcodes):
  - T1: Ep, Lm.
  - T2: Cp.
  - T3: Er, Li.
- LDA:
  - T4: Ei, Lm.
  - T5: Er, La.
  - T6: none.
- ADD:
  - T4: Ei, Lm.
  - T5: Er, Lb.
  - T6: Eu, La.
- SUB: same as ADD, except T6 asserts Eu, La, Su.
- OUT:
  - T4: Ea, Lo.
  - T5, T6: none.
- HLT:
  - T4: no controls; the next edge enters HALT.
  - HALT: all controls 0, halted=1, t_state=0. The block stays in HALT until Reset_n is asserted.
- FAST_CYCLE=1:
  - LDA: T5→T1.
  - OUT: T4→T1.
  - NOP: T4→T1.
  - ADD/SUB: unchanged at 6 cycles.
- Bus: the block drives data_bus only when Ei=1. The IR never drives the upper nibble with anything but 0.

## Timing
- Reset (Reset_n low, asynchronous):
  - state=T1, IR=0x00, halted=0.
  - All control outputs are forced to 0 while Reset_n is low (gated, not just decoded), so T1 controls do not assert during reset.
  - t_state reads 000001.
  - data_bus is high-Z.
- The first cycle after reset deassertion is T1, with Ep and Lm asserted.
- Reset_n asserted mid-instruction aborts immediately. There is no partial completion and the IR clears.
- The IR value is valid from T4 onward. The T1–T3 decode uses only the state, never a stale IR.
- The Li load and the Er bus drive are in the same cycle (T3); memory data must be stable before that edge.
- Ei and Er are never both 1 in any state, and neither are any two bus drivers (Ep, Er, Ei, Ea, Eu).
- Latency with FAST_CYCLE=0: each instruction takes 6 cycles; HLT reaches HALT 4 cycles after its T1.

## Test plan
- Reset mid-T5 of an ADD, with Reset_n held low for 3 cycles:
  - While low: all controls 0, IR=0x00, data_bus high-Z.
  - First cycle after release: T1 with Ep=Lm=1.
- Full program with behavioural PC, A, B and ALU models and the memory image (LDA 13, OUT, ADD 14, OUT, SUB 15, OUT, HLT; data 8, 5, 4), FAST_CYCLE=0:
  - Lo pulses with bus values 8, 13, 9.
  - halted rises at cycle 40 after reset release.
- Same program with FAST_CYCLE=1:
  - Same outputs 8, 13, 9.
  - halted rises at cycle 33.
- Opcode 0x5A (NOP) followed by OUT, FAST_CYCLE=0:
  - No controls during T4–T6 of the NOP.
  - data_bus is not driven by this block in that window.
  - The OUT proceeds normally.
- Bus-contention check across the full program: at most one of Ep, Er, Ei, Ea, Eu is high per cycle.
  - In the LDA 13 T4 cycle, the block drives 0x0D on data_bus.
- In HALT for 20 cycles:
  - All controls stay 0, t_state=0, halted=1.
  - Reset_n pulse low returns the block to T1 with halted=0.
